// File: rtl/beta_csr_pkg.sv
// Shared CSR/trap definitions: cause codes, privilege encodings, trap FSM states
// and the live CSR view the trap control unit consumes.
package beta_csr_pkg;

   localparam int XLEN    = 32;
   localparam int CAUSE_W = 5;
   localparam int EXC_W   = 6;

   localparam logic [1:0] PRIV_M = 2'b11;
   localparam logic [1:0] PRIV_U = 2'b00;

   localparam logic [CAUSE_W-1:0] CAUSE_IF_MISAL = 5'd0;
   localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL  = 5'd2;
   localparam logic [CAUSE_W-1:0] CAUSE_BREAK    = 5'd3;
   localparam logic [CAUSE_W-1:0] CAUSE_LD_MISAL = 5'd4;
   localparam logic [CAUSE_W-1:0] CAUSE_ST_MISAL = 5'd6;
   localparam logic [CAUSE_W-1:0] CAUSE_ECALL_U  = 5'd8;
   localparam logic [CAUSE_W-1:0] CAUSE_ECALL_M  = 5'd11;
   localparam logic [CAUSE_W-1:0] IRQ_MSI        = 5'd3;
   localparam logic [CAUSE_W-1:0] IRQ_MTI        = 5'd7;
   localparam logic [CAUSE_W-1:0] IRQ_MEI        = 5'd11;

   // Bit positions inside exc_req: {st_misal,ld_misal,ecall,ebreak,illegal,if_misal}
   localparam int EXC_IF_MISAL = 0;
   localparam int EXC_ILLEGAL  = 1;
   localparam int EXC_BREAK    = 2;
   localparam int EXC_ECALL    = 3;
   localparam int EXC_LD_MISAL = 4;
   localparam int EXC_ST_MISAL = 5;

   // Bit positions inside the packed interrupt pend/en vectors
   localparam int IRQ_IDX_SOFT = 0;
   localparam int IRQ_IDX_TIM  = 1;
   localparam int IRQ_IDX_EXT  = 2;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CAPTURE  = 2'd1,
      RESTORE  = 2'd2,
      REDIRECT = 2'd3
   } tcu_state_t;

   typedef struct packed {
      logic            mie;
      logic            mpie;
      logic            mpp;
      logic [XLEN-1:0] mtvec;
      logic [XLEN-1:0] mepc;
      logic [XLEN-1:0] mcause;
      logic [XLEN-1:0] mtval;
      logic            ext_int_pend;
      logic            ext_int_en;
      logic            tim_int_pend;
      logic            tim_int_en;
      logic            soft_int_pend;
      logic            soft_int_en;
   } csr_ctrl_t;

endpackage

// File: rtl/beta_trap_prio_enc.sv
// Combinational trap priority encoder: picks the winning interrupt or exception
// for the instruction at commit and reports its cause code.
module beta_trap_prio_enc
   import beta_csr_pkg::*;
(
   input  logic [EXC_W-1:0]   exc_req,
   input  logic               mie,
   input  logic [2:0]         irq_pend,
   input  logic [2:0]         irq_en,
   input  logic [1:0]         priv,
   output logic               take,
   output logic               is_irq,
   output logic [CAUSE_W-1:0] cause
);

   logic       irq_on;
   logic [2:0] irq_take;

   always_comb begin
      irq_on   = (priv == PRIV_U) | mie;
      irq_take = irq_pend & irq_en & {3{irq_on}};
      take     = 1'b1;
      is_irq   = 1'b1;
      cause    = '0;
      if (irq_take[IRQ_IDX_EXT]) begin
         cause = IRQ_MEI;
      end else if (irq_take[IRQ_IDX_SOFT]) begin
         cause = IRQ_MSI;
      end else if (irq_take[IRQ_IDX_TIM]) begin
         cause = IRQ_MTI;
      end else begin
         is_irq = 1'b0;
         if (exc_req[EXC_IF_MISAL]) begin
            cause = CAUSE_IF_MISAL;
         end else if (exc_req[EXC_ILLEGAL]) begin
            cause = CAUSE_ILLEGAL;
         end else if (exc_req[EXC_BREAK]) begin
            cause = CAUSE_BREAK;
         end else if (exc_req[EXC_ECALL]) begin
            cause = (priv == PRIV_M) ? CAUSE_ECALL_M : CAUSE_ECALL_U;
         end else if (exc_req[EXC_LD_MISAL]) begin
            cause = CAUSE_LD_MISAL;
         end else if (exc_req[EXC_ST_MISAL]) begin
            cause = CAUSE_ST_MISAL;
         end else begin
            take = 1'b0;
         end
      end
   end

endmodule

// File: rtl/beta_trap_ctrl_unit.sv
// Trap control unit: arbitrates exceptions/interrupts at commit, drives the CSR
// trap-capture write, handles MRET, tracks privilege and redirects fetch.
module beta_trap_ctrl_unit
   import beta_csr_pkg::*;
#(
   parameter int DataWidth = XLEN
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 instr_valid_i,
   input  logic [DataWidth-1:0] instr_pc_i,
   input  logic [EXC_W-1:0]     exc_req_i,
   input  logic [DataWidth-1:0] exc_tval_i,
   input  logic                 mret_i,
   input  csr_ctrl_t            csr_control_i,
   output logic                 tcu_csr_we_o,
   output logic [DataWidth-1:0] csr_mcause_o,
   output logic [DataWidth-1:0] csr_mepc_o,
   output logic [DataWidth-1:0] csr_mtval_o,
   output logic [2:0]           csr_trap_state_o,
   output logic [1:0]           priv_lvl_o,
   output logic                 flush_o,
   output logic                 stall_o,
   output logic                 redirect_o,
   output logic [DataWidth-1:0] redirect_pc_o,
   output tcu_state_t           dbg_state_o
);

   tcu_state_t state_q, state_d;

   logic [1:0]           priv_q;
   logic                 restore_mpp_q;
   logic [DataWidth-1:0] mcause_q, mepc_q, mtval_q, target_q;
   logic [2:0]           trap_state_q;

   logic [EXC_W-1:0]     exc_eff;
   logic                 take, is_irq, use_tval, do_restore, sample;
   logic [CAUSE_W-1:0]   cause;
   logic [DataWidth-1:0] cause_full, tvec_base, tvec_off, trap_target;

   // MRET from U-mode is reported as an illegal instruction, never as a restore
   always_comb begin
      exc_eff              = exc_req_i;
      exc_eff[EXC_ILLEGAL] = exc_req_i[EXC_ILLEGAL] | (mret_i & (priv_q == PRIV_U));
   end

   beta_trap_prio_enc u_prio_enc (
      .exc_req  (exc_eff),
      .mie      (csr_control_i.mie),
      .irq_pend ({csr_control_i.ext_int_pend, csr_control_i.tim_int_pend,
                  csr_control_i.soft_int_pend}),
      .irq_en   ({csr_control_i.ext_int_en, csr_control_i.tim_int_en,
                  csr_control_i.soft_int_en}),
      .priv     (priv_q),
      .take     (take),
      .is_irq   (is_irq),
      .cause    (cause)
   );

   assign sample     = (state_q == IDLE) & instr_valid_i;
   assign do_restore = mret_i & (priv_q == PRIV_M) & ~take;
   assign use_tval   = ~is_irq & (cause != CAUSE_ECALL_U) & (cause != CAUSE_ECALL_M);

   assign cause_full  = {is_irq, {(DataWidth-1-CAUSE_W){1'b0}}, cause};
   assign tvec_base   = {csr_control_i.mtvec[DataWidth-1:2], 2'b00};
   assign tvec_off    = {{(DataWidth-CAUSE_W-2){1'b0}}, cause, 2'b00};
   assign trap_target = (is_irq && (csr_control_i.mtvec[1:0] == 2'b01))
                        ? tvec_base + tvec_off : tvec_base;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (sample && take) begin
               state_d = CAPTURE;
            end else if (sample && do_restore) begin
               state_d = RESTORE;
            end
         end
         CAPTURE:  state_d = REDIRECT;
         RESTORE:  state_d = REDIRECT;
         REDIRECT: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Everything the write and redirect need is frozen on IDLE exit
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         mcause_q      <= '0;
         mepc_q        <= '0;
         mtval_q       <= '0;
         trap_state_q  <= '0;
         target_q      <= '0;
         restore_mpp_q <= 1'b0;
      end else if (sample && take) begin
         mcause_q     <= cause_full;
         mepc_q       <= instr_pc_i;
         mtval_q      <= use_tval ? exc_tval_i : '0;
         trap_state_q <= {1'b0, csr_control_i.mie, priv_q == PRIV_M};
         target_q     <= trap_target;
      end else if (sample && do_restore) begin
         mcause_q      <= csr_control_i.mcause;
         mepc_q        <= csr_control_i.mepc;
         mtval_q       <= csr_control_i.mtval;
         trap_state_q  <= {csr_control_i.mpie, 1'b1, 1'b0};
         target_q      <= csr_control_i.mepc;
         restore_mpp_q <= csr_control_i.mpp;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         priv_q <= PRIV_M;
      end else if (state_q == CAPTURE) begin
         priv_q <= PRIV_M;
      end else if (state_q == RESTORE) begin
         priv_q <= restore_mpp_q ? PRIV_M : PRIV_U;
      end
   end

   assign tcu_csr_we_o     = (state_q == CAPTURE) | (state_q == RESTORE);
   assign flush_o          = tcu_csr_we_o;
   assign stall_o          = (state_q != IDLE);
   assign redirect_o       = (state_q == REDIRECT);
   assign redirect_pc_o    = target_q;
   assign csr_mcause_o     = mcause_q;
   assign csr_mepc_o       = mepc_q;
   assign csr_mtval_o      = mtval_q;
   assign csr_trap_state_o = trap_state_q;
   assign priv_lvl_o       = priv_q;
   assign dbg_state_o      = state_q;

endmodule
